// File: rtl/multiplier_parallel.sv
// Unsigned 32x32->64 parallel multiplier: partial products reduced by a 3:2 carry-save
// tree, one final carry-propagate add, registered output. Option: MULT_PARALLEL_VALID_EN.
module multiplier_parallel (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MULT_PARALLEL_VALID_EN
    output logic [63:0] r,
    input  logic        valid_in,
    output logic        valid_out
`else
    output logic [63:0] r
`endif
);

    logic [63:0] w_product;

    // Each layer compresses groups of three rows into sum/carry rows; leftovers pass through.
    // Row counts per layer: 32,22,15,10,7,5,4,3,2 -- eight layers reach two rows.
    always_comb begin
        logic [63:0] w_cur [32];
        logic [63:0] w_nxt [32];
        logic [63:0] w_x, w_y, w_z;
        int unsigned n;
        int unsigned m;

        for (int unsigned i = 0; i < 32; i++) begin
            w_cur[i] = b[i] ? ({32'b0, a} << i) : '0;
        end
        n = 32;
        for (int unsigned l = 0; l < 8; l++) begin
            for (int unsigned k = 0; k < 32; k++) begin
                w_nxt[k] = '0;
            end
            m = 0;
            for (int unsigned g = 0; g < 11; g++) begin
                if (3 * g + 2 < n) begin
                    w_x = w_cur[3 * g];
                    w_y = w_cur[3 * g + 1];
                    w_z = w_cur[3 * g + 2];
                    w_nxt[m]     = w_x ^ w_y ^ w_z;
                    w_nxt[m + 1] = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
                    m = m + 2;
                end else if (3 * g < n) begin
                    w_nxt[m] = w_cur[3 * g];
                    m = m + 1;
                    if (3 * g + 1 < n) begin
                        w_nxt[m] = w_cur[3 * g + 1];
                        m = m + 1;
                    end
                end
            end
            w_cur = w_nxt;
            n = m;
        end
        w_product = w_cur[0] + w_cur[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
        end else begin
            r <= w_product;
        end
    end

`ifdef MULT_PARALLEL_VALID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
        end
    end
`endif

endmodule

// File: tb/tb_multiplier_parallel.sv
// Self-checking bench for multiplier_parallel; reference products come from plain 64-bit arithmetic.
module tb_multiplier_parallel;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
`ifdef MULT_PARALLEL_VALID_EN
    logic        valid_in;
    logic        valid_out;
`endif

    int checks;
    int errors;

    multiplier_parallel dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
`ifdef MULT_PARALLEL_VALID_EN
        .r        (r),
        .valid_in (valid_in),
        .valid_out(valid_out)
`else
        .r        (r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] golden(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // Apply operands at the falling edge, then wait until just after the next rising edge.
    task automatic step(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [63:0] exp;
        #1;
        checks++;
        if (r !== 64'h0) begin
            errors++;
            $display("FAIL reset_initial: r=%h expected=%h", r, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        step(32'd3, 32'd5);
        checks++;
        if (r !== 64'd15) begin
            errors++;
            $display("FAIL reset_preload: r=%h expected=%h", r, 64'd15);
        end
        @(negedge clk);
        a = 32'h12345678;
        b = 32'h9ABCDEF0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (r !== 64'h0) begin
            errors++;
            $display("FAIL reset_async: r=%h expected=%h", r, 64'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (r !== 64'h0) begin
            errors++;
            $display("FAIL reset_held: r=%h expected=%h", r, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp = 64'h0B00EA4E242D2080;
        checks++;
        if (r !== exp) begin
            errors++;
            $display("FAIL reset_release: r=%h expected=%h", r, exp);
        end
    endtask

    task automatic test_simple;
        logic [31:0] xs [4];
        logic [31:0] ys [4];
        logic [63:0] es [4];
        xs = '{32'd0, 32'd3, 32'h10000, 32'd1};
        ys = '{32'd0, 32'd5, 32'h10000, 32'hFFFFFFFF};
        es = '{64'd0, 64'd15, 64'h0000000100000000, 64'h00000000FFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            step(xs[i], ys[i]);
            checks++;
            if (r !== es[i]) begin
                errors++;
                $display("FAIL simple[%0d]: r=%h expected=%h", i, r, es[i]);
            end
        end
    endtask

    task automatic test_extremes;
        logic [31:0] xs [3];
        logic [31:0] ys [3];
        logic [63:0] es [3];
        xs = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        ys = '{32'hFFFFFFFF, 32'd2, 32'd0};
        es = '{64'hFFFFFFFE00000001, 64'h0000000100000000, 64'd0};
        for (int i = 0; i < 3; i++) begin
            step(xs[i], ys[i]);
            checks++;
            if (r !== es[i]) begin
                errors++;
                $display("FAIL extreme[%0d]: r=%h expected=%h", i, r, es[i]);
            end
        end
        // Held operands keep the product steady.
        step(32'hDEADBEEF, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        checks++;
        if (r !== golden(32'hDEADBEEF, 32'hCAFEF00D)) begin
            errors++;
            $display("FAIL hold: r=%h expected=%h", r, golden(32'hDEADBEEF, 32'hCAFEF00D));
        end
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 10 == 0) x = {x[31:16], 16'h0};
            if (i % 15 == 0) y = 32'hFFFFFFFF;
            step(x, y);
            checks++;
            if (r !== golden(x, y)) begin
                errors++;
                $display("FAIL random[%0d] %h*%h: r=%h expected=%h", i, x, y, r, golden(x, y));
            end
        end
    endtask

    task automatic test_stream;
        logic [31:0] x, y;
        x = '0;
        y = '0;
        for (int i = 0; i < 100; i++) begin
            step(x, y);
            checks++;
            if (r !== golden(x, y)) begin
                errors++;
                $display("FAIL stream[%0d]: r=%h expected=%h", i, r, golden(x, y));
            end
            if (i == 50) begin
                #2;
                reset = 1'b1;
                #1;
                checks++;
                if (r !== 64'h0) begin
                    errors++;
                    $display("FAIL stream_reset: r=%h expected=%h", r, 64'h0);
                end
                step(x + 32'h11111111, y);
                checks++;
                if (r !== 64'h0) begin
                    errors++;
                    $display("FAIL stream_reset_held: r=%h expected=%h", r, 64'h0);
                end
                @(negedge clk);
                reset = 1'b0;
            end
            x = x + 32'h23456789;
            y = y + 32'h34567891;
        end
    endtask

`ifdef MULT_PARALLEL_VALID_EN
    task automatic test_valid;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = pat[i];
            @(posedge clk);
            #1;
            checks++;
            if (valid_out !== pat[i]) begin
                errors++;
                $display("FAIL valid[%0d]: valid_out=%b expected=%b", i, valid_out, pat[i]);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL valid_reset: valid_out=%b expected=0", valid_out);
        end
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        a = '0;
        b = '0;
`ifdef MULT_PARALLEL_VALID_EN
        valid_in = 1'b0;
`endif
        test_reset();
        test_simple();
        test_extremes();
        test_random();
        test_stream();
`ifdef MULT_PARALLEL_VALID_EN
        test_valid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
